nts_dispatch_buffer: RTL and testbench

Producer side of the dispatch interface consumed by the NTS engine. It accepts 64-bit frame words from the Ethernet receive path and stores complete frames in a two-bank ping-pong packet memory. It presents one committed frame at a time to the engine as a first-word-fall-through FIFO with packet-available and discard handshakes. Receive can fill one bank while the engine drains the other.

---
 rtl/nts_dispatch_pkg.sv | 20 ++
 rtl/nts_dispatch_buffer_bram_dp.sv | 30 +++
 rtl/nts_dispatch_buffer.sv | 235 +++++++++++++++++++++++
 tb/tb_nts_dispatch_buffer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nts_dispatch_pkg.sv
// Shared definitions for the NTS dispatch buffer.
// Contents: the write-side and read-side state encodings, and the byte mask
// that marks a completely filled 64-bit word.
package nts_dispatch_pkg;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_WRITE = 2'd1,
    W_DROP  = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE     = 2'd0,
    R_PREFETCH = 2'd1,
    R_AVAIL    = 2'd2
  } rd_state_e;

  localparam logic [7:0] BYTE_MASK_FULL = 8'hFF;

endpackage

// File: rtl/nts_dispatch_buffer_bram_dp.sv
// Simple dual-port packet memory: one write port and one registered read port.
// Ports:
//   i_clk    clock
//   i_we     write enable
//   i_waddr  write address (MSB selects the bank)
//   i_wdata  write data
//   i_raddr  read address (MSB selects the bank)
//   o_rdata  read data, valid one cycle after i_raddr is presented
module bram_dp #(
  parameter int AW = 11,
  parameter int DW = 64
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
    o_rdata <= mem[i_raddr];
  end

endmodule

// File: rtl/nts_dispatch_buffer.sv
// Dispatch buffer between the Ethernet receive path and the NTS engine.
// Complete frames land in one of two memory banks; the engine sees one
// committed frame at a time as a first-word-fall-through FIFO.
// Ports:
//   i_clk, i_areset                  clock, synchronous active-high reset
//   i_rx_*                           receive word stream (no backpressure)
//   o_dispatch_packet_available      a committed frame is presented
//   i_dispatch_packet_read_discard   engine releases the presented frame
//   o_dispatch_data_valid            byte mask of the presented frame's last word
//   o_dispatch_fifo_empty            no unread words left in the presented frame
//   i_dispatch_fifo_rd_en            pop the head word
//   o_dispatch_fifo_rd_data          head word
//   o_drop_count                     dropped frames, wrapping
//
// Write FSM
//   state      | meaning
//   W_IDLE     | waiting for a first word
//   W_WRITE    | storing words into bank[wr_bank]
//   W_DROP     | swallowing words until last, then counting one drop
// Read FSM
//   state      | meaning
//   R_IDLE     | waiting for bank[rd_bank] to fill; reads word 0
//   R_PREFETCH | word 0 arriving in the memory output register
//   R_AVAIL    | frame presented to the engine
module nts_dispatch_buffer
  import nts_dispatch_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        i_clk,
  input  logic        i_areset,
  input  logic        i_rx_valid,
  input  logic        i_rx_first,
  input  logic        i_rx_last,
  input  logic        i_rx_bad,
  input  logic [63:0] i_rx_data,
  input  logic [7:0]  i_rx_data_valid,
  output logic        o_dispatch_packet_available,
  input  logic        i_dispatch_packet_read_discard,
  output logic [7:0]  o_dispatch_data_valid,
  output logic        o_dispatch_fifo_empty,
  input  logic        i_dispatch_fifo_rd_en,
  output logic [63:0] o_dispatch_fifo_rd_data,
  output logic [31:0] o_drop_count
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] BANK_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [1:0]    bank_full;
  logic [CW-1:0] bank_count [2];
  logic [7:0]    bank_mask  [2];
  logic          wr_bank;
  logic          rd_bank;

  wr_state_e       wr_state, wr_state_nxt;
  logic [CW-1:0]   wr_cnt, wr_cnt_nxt;
  logic [CW-1:0]   fin_cnt;
  logic [ADDR_WIDTH-1:0] wr_off;
  logic            mem_we;
  logic            commit;
  logic            abort;
  logic            fin_drop;
  logic [31:0]     drop_count;

  rd_state_e       rd_state;
  logic [CW-1:0]   rd_ptr;
  logic [ADDR_WIDTH-1:0] rd_off;
  logic            avail;
  logic            rd_empty;
  logic            pop;
  logic            discard_fire;
  logic [63:0]     mem_rdata;

  // ---------------- write side ----------------
  always_comb begin
    wr_state_nxt = wr_state;
    wr_cnt_nxt   = wr_cnt;
    fin_cnt      = wr_cnt;
    wr_off       = '0;
    mem_we       = 1'b0;
    commit       = 1'b0;
    abort        = 1'b0;
    fin_drop     = 1'b0;
    if (i_rx_valid) begin
      case (wr_state)
        W_IDLE, W_WRITE: begin
          if (i_rx_first) begin
            // a new first word mid-frame throws away the partial frame
            abort = (wr_state == W_WRITE);
            if (bank_full[wr_bank]) begin
              if (i_rx_last) begin
                fin_drop     = 1'b1;
                wr_state_nxt = W_IDLE;
              end else begin
                wr_state_nxt = W_DROP;
              end
            end else begin
              mem_we = 1'b1;
              wr_off = '0;
              if (i_rx_last) begin
                fin_drop     = i_rx_bad;
                commit       = !i_rx_bad;
                fin_cnt      = CW'(1);
                wr_state_nxt = W_IDLE;
              end else begin
                wr_cnt_nxt   = CW'(1);
                wr_state_nxt = W_WRITE;
              end
            end
          end else if (wr_state == W_WRITE) begin
            if (wr_cnt == BANK_WORDS) begin
              if (i_rx_last) begin
                fin_drop     = 1'b1;
                wr_state_nxt = W_IDLE;
              end else begin
                wr_state_nxt = W_DROP;
              end
            end else begin
              mem_we = 1'b1;
              wr_off = wr_cnt[ADDR_WIDTH-1:0];
              if (i_rx_last) begin
                fin_drop     = i_rx_bad;
                commit       = !i_rx_bad;
                fin_cnt      = wr_cnt + CW'(1);
                wr_state_nxt = W_IDLE;
              end else begin
                wr_cnt_nxt = wr_cnt + CW'(1);
              end
            end
          end
        end
        W_DROP: begin
          if (i_rx_last) begin
            fin_drop     = 1'b1;
            wr_state_nxt = W_IDLE;
          end
        end
        default: wr_state_nxt = W_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      wr_state   <= W_IDLE;
      wr_cnt     <= '0;
      wr_bank    <= 1'b0;
      drop_count <= '0;
      bank_count <= '{default: '0};
      bank_mask  <= '{default: '0};
    end else begin
      wr_state   <= wr_state_nxt;
      wr_cnt     <= wr_cnt_nxt;
      drop_count <= drop_count + 32'(abort) + 32'(fin_drop);
      if (commit) begin
        bank_count[wr_bank] <= fin_cnt;
        bank_mask[wr_bank]  <= i_rx_data_valid;
        wr_bank             <= ~wr_bank;
      end
    end
  end

  // Set by the writer, cleared by the reader. A commit and a discard can
  // never target the same bank: commit needs it empty, discard needs it full.
  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      bank_full <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (commit && (wr_bank == 1'(b))) begin
          bank_full[b] <= 1'b1;
        end else if (discard_fire && (rd_bank == 1'(b))) begin
          bank_full[b] <= 1'b0;
        end
      end
    end
  end

  // ---------------- read side ----------------
  assign avail        = (rd_state == R_AVAIL);
  assign rd_empty     = (rd_ptr == bank_count[rd_bank]);
  assign discard_fire = avail && i_dispatch_packet_read_discard;
  assign pop          = avail && i_dispatch_fifo_rd_en && !rd_empty;
  // The memory output register is the FIFO head: addressing ptr+1 while
  // popping makes the next word appear on the following cycle.
  assign rd_off       = rd_ptr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(pop);

  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      rd_state <= R_IDLE;
      rd_bank  <= 1'b0;
      rd_ptr   <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (bank_full[rd_bank]) begin
            rd_state <= R_PREFETCH;
          end
        end
        R_PREFETCH: rd_state <= R_AVAIL;
        R_AVAIL: begin
          if (i_dispatch_packet_read_discard) begin
            rd_state <= R_IDLE;
            rd_bank  <= ~rd_bank;
            rd_ptr   <= '0;
          end else if (pop) begin
            rd_ptr <= rd_ptr + CW'(1);
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  bram_dp #(
    .AW(CW),
    .DW(64)
  ) u_bram (
    .i_clk  (i_clk),
    .i_we   (mem_we),
    .i_waddr({wr_bank, wr_off}),
    .i_wdata(i_rx_data),
    .i_raddr({rd_bank, rd_off}),
    .o_rdata(mem_rdata)
  );

  assign o_dispatch_packet_available = avail;
  assign o_dispatch_data_valid       = avail ? bank_mask[rd_bank] : 8'h00;
  assign o_dispatch_fifo_empty       = !avail || rd_empty;
  // head reads as zero whenever there is nothing valid to present
  assign o_dispatch_fifo_rd_data     = (avail && !rd_empty) ? mem_rdata : 64'd0;
  assign o_drop_count                = drop_count;

endmodule

// File: tb/tb_nts_dispatch_buffer.sv
module tb_nts_dispatch_buffer;
  import nts_dispatch_pkg::*;

  localparam int AW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid, rx_first, rx_last, rx_bad;
  logic [63:0] rx_data;
  logic [7:0]  rx_dv;
  logic        avail;
  logic        discard;
  logic [7:0]  d_dv;
  logic        empty;
  logic        rd_en;
  logic [63:0] rd_data;
  logic [31:0] drop_count;

  always #5 clk = ~clk;

  nts_dispatch_buffer #(.ADDR_WIDTH(AW)) dut (
    .i_clk                         (clk),
    .i_areset                      (rst),
    .i_rx_valid                    (rx_valid),
    .i_rx_first                    (rx_first),
    .i_rx_last                     (rx_last),
    .i_rx_bad                      (rx_bad),
    .i_rx_data                     (rx_data),
    .i_rx_data_valid               (rx_dv),
    .o_dispatch_packet_available   (avail),
    .i_dispatch_packet_read_discard(discard),
    .o_dispatch_data_valid         (d_dv),
    .o_dispatch_fifo_empty         (empty),
    .i_dispatch_fifo_rd_en         (rd_en),
    .o_dispatch_fifo_rd_data       (rd_data),
    .o_drop_count                  (drop_count)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];
  int          len_q[$];
  int          mon_popped = 0;

  function automatic logic [63:0] word_of(input int id, input int idx);
    logic [31:0] a;
    logic [31:0] b;
    a = id;
    b = idx;
    return {a[7:0], b[7:0], 16'hC0DE, a[15:0] ^ 16'h5A5A, b[15:0] + 16'h1000};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive n words back to back; push them to the scoreboard when the frame
  // is expected to be presented.
  task automatic send_words(input int id, input int n, input logic [7:0] mask,
                            input bit bad, input bit with_first, input bit with_last,
                            input bit expect_commit);
    if (expect_commit) begin
      for (int i = 0; i < n; i++) exp_q.push_back(word_of(id, i));
      len_q.push_back(n);
    end
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_first = with_first && (i == 0);
      rx_last  = with_last && (i == n - 1);
      rx_bad   = bad && rx_last;
      rx_data  = word_of(id, i);
      rx_dv    = rx_last ? mask : BYTE_MASK_FULL;
      tick(1);
    end
    rx_valid = 1'b0;
    rx_first = 1'b0;
    rx_last  = 1'b0;
    rx_bad   = 1'b0;
  endtask

  task automatic read_words(input int n);
    rd_en = 1'b1;
    tick(n);
    rd_en = 1'b0;
  endtask

  task automatic discard_frame();
    int rem;
    logic [63:0] dummy;
    discard = 1'b1;
    tick(1);
    discard = 1'b0;
    if (len_q.size() > 0) begin
      rem = len_q.pop_front() - mon_popped;
      repeat (rem) dummy = exp_q.pop_front();
    end
    mon_popped = 0;
  endtask

  // Monitor: every word the DUT hands over is checked against the scoreboard.
  initial begin
    logic [63:0] w;
    forever begin
      @(negedge clk);
      if (!rst && avail && rd_en && !empty) begin
        if (len_q.size() == 0 || mon_popped >= len_q[0]) begin
          n_checks++;
          n_errors++;
          $display("FAIL extra_pop: got %0h expected no word", rd_data);
        end else begin
          w = exp_q.pop_front();
          check("rd_data", rd_data, w);
          mon_popped++;
        end
      end
    end
  end

  initial begin
    rst = 1'b1; rx_valid = 0; rx_first = 0; rx_last = 0; rx_bad = 0;
    rx_data = '0; rx_dv = '0; discard = 0; rd_en = 0;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_avail", {63'd0, avail}, 64'd0);
    check("rst_empty", {63'd0, empty}, 64'd1);
    check("rst_dv", {56'd0, d_dv}, 64'd0);
    check("rst_drop", {32'd0, drop_count}, 64'd0);
    check("rst_data", rd_data, 64'd0);

    // single 5-word frame, mask 0f
    send_words(1, 5, 8'h0f, 0, 1, 1, 1);
    tick(1);
    check("t1_avail_c2", {63'd0, avail}, 64'd0);
    tick(1);
    check("t1_avail_c3", {63'd0, avail}, 64'd1);
    check("t1_dv", {56'd0, d_dv}, 64'h0f);
    check("t1_empty0", {63'd0, empty}, 64'd0);
    check("t1_head", rd_data, word_of(1, 0));
    read_words(5);
    check("t1_empty1", {63'd0, empty}, 64'd1);
    check("t1_popped", mon_popped, 5);
    read_words(2);
    check("t1_empty_rd_empty", {63'd0, empty}, 64'd1);
    check("t1_empty_rd_head", rd_data, 64'd0);
    check("t1_empty_rd_avail", {63'd0, avail}, 64'd1);
    discard_frame();
    check("t1_disc_avail", {63'd0, avail}, 64'd0);
    check("t1_disc_dv", {56'd0, d_dv}, 64'd0);

    // two back-to-back frames fill both banks; the third is dropped
    send_words(2, 3, 8'hff, 0, 1, 1, 1);
    send_words(3, 3, 8'hff, 0, 1, 1, 1);
    send_words(4, 3, 8'hff, 0, 1, 1, 0);
    tick(3);
    check("t2_drop", {32'd0, drop_count}, 64'd1);
    check("t2_avail", {63'd0, avail}, 64'd1);
    check("t2_dv", {56'd0, d_dv}, 64'hff);
    check("t2_head", rd_data, word_of(2, 0));
    read_words(3);
    discard_frame();
    check("t2_avail_d1", {63'd0, avail}, 64'd0);
    tick(1);
    check("t2_avail_d2", {63'd0, avail}, 64'd0);
    tick(1);
    check("t2_avail_d3", {63'd0, avail}, 64'd1);
    check("t2_head2", rd_data, word_of(3, 0));
    read_words(3);
    check("t2_popped", mon_popped, 3);
    discard_frame();

    // bad frame
    send_words(5, 4, 8'hff, 1, 1, 1, 0);
    tick(4);
    check("t3_avail", {63'd0, avail}, 64'd0);
    check("t3_drop", {32'd0, drop_count}, 64'd2);

    // 17 words overflow a 16-word bank; 16 words fit exactly
    send_words(6, 17, 8'hff, 0, 1, 1, 0);
    tick(4);
    check("t4_drop", {32'd0, drop_count}, 64'd3);
    check("t4_avail", {63'd0, avail}, 64'd0);
    send_words(7, 16, 8'h01, 0, 1, 1, 1);
    tick(1);
    check("t4_avail_c2", {63'd0, avail}, 64'd0);
    tick(1);
    check("t4_avail_c3", {63'd0, avail}, 64'd1);
    check("t4_dv", {56'd0, d_dv}, 64'h01);
    read_words(16);
    check("t4_empty", {63'd0, empty}, 64'd1);
    check("t4_popped", mon_popped, 16);
    check("t4_drop2", {32'd0, drop_count}, 64'd3);
    discard_frame();

    // partial read then discard; next frame starts from word 0
    send_words(8, 6, 8'h3f, 0, 1, 1, 1);
    tick(2);
    check("t5_dv", {56'd0, d_dv}, 64'h3f);
    read_words(2);
    check("t5_popped", mon_popped, 2);
    check("t5_empty", {63'd0, empty}, 64'd0);
    discard_frame();
    send_words(9, 3, 8'h07, 0, 1, 1, 1);
    tick(2);
    check("t5_head", rd_data, word_of(9, 0));
    check("t5_dv2", {56'd0, d_dv}, 64'h07);
    read_words(3);
    check("t5_empty2", {63'd0, empty}, 64'd1);
    discard_frame();

    // reset in the middle of both a read and a write
    send_words(10, 4, 8'hff, 0, 1, 1, 1);
    tick(2);
    read_words(1);
    send_words(11, 2, 8'hff, 0, 1, 0, 0);
    rst = 1'b1;
    rx_valid = 1'b1;
    rx_data = word_of(11, 2);
    rd_en = 1'b1;
    tick(1);
    rst = 1'b0;
    rx_valid = 1'b0;
    rd_en = 1'b0;
    exp_q.delete();
    len_q.delete();
    mon_popped = 0;
    check("t6_avail", {63'd0, avail}, 64'd0);
    check("t6_empty", {63'd0, empty}, 64'd1);
    check("t6_drop", {32'd0, drop_count}, 64'd0);
    check("t6_dv", {56'd0, d_dv}, 64'd0);
    send_words(11, 3, 8'hff, 0, 0, 1, 0);
    tick(4);
    check("t6_trail_avail", {63'd0, avail}, 64'd0);
    check("t6_trail_drop", {32'd0, drop_count}, 64'd0);
    send_words(12, 2, 8'h03, 0, 1, 1, 1);
    tick(2);
    check("t6_new_avail", {63'd0, avail}, 64'd1);
    check("t6_new_dv", {56'd0, d_dv}, 64'h03);
    read_words(2);
    check("t6_popped", mon_popped, 2);
    discard_frame();
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
